mc_ctrl: RTL

Parametrised multicycle MIPS control unit: the successor to the team's 8-state fixed-subset controller. It sequences IF/ID/EXE/MEM/WB for 15 instructions and drives every datapath enable and mux select. It adds an optional memory wait-state handshake, illegal-opcode detection and a retired-instruction counter. It sits between the instruction register (op/funct) and the datapath (PC, IR, regfile, ALU, DM).

---
 rtl/mc_ctrl_if.sv | 33 +++
 rtl/mc_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle controller and the MIPS datapath:
// instruction fields and status in, enables and mux selects out.
interface mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_we;
   logic       ir_we;
   logic       reg_we;
   logic       dm_we;
   logic       dm_re;
   logic [2:0] alu_ctr;
   logic [1:0] npc_sel;
   logic [1:0] ext_op;
   logic [1:0] reg_dst_sel;
   logic [1:0] mem_to_reg_sel;
   logic       alu_src_sel;
   logic [3:0] state_out;
   logic       illegal;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_we, ir_we, reg_we, dm_we, dm_re, alu_ctr, npc_sel, ext_op,
             reg_dst_sel, mem_to_reg_sel, alu_src_sel, state_out, illegal
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_we, ir_we, reg_we, dm_we, dm_re, alu_ctr, npc_sel, ext_op,
             reg_dst_sel, mem_to_reg_sel, alu_src_sel, state_out, illegal
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: IF/ID/EXE/MEM/WB sequencing for 15 instructions,
// optional memory wait states, illegal-opcode pulse and retired-instruction counter.
module mc_ctrl #(
   parameter bit          MEM_WAIT = 1'b0,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   mc_ctrl_if.master        bus,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EXE_ALU = 4'd2,
      S_EXE_BR  = 4'd3,
      S_EXE_MEM = 4'd4,
      S_MEM_RD  = 4'd5,
      S_MEM_WR  = 4'd6,
      S_WB_ALU  = 4'd7,
      S_WB_LD   = 4'd8
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t     state, state_nx;
   logic       is_r, i_add, i_sub, i_and, i_or, i_slt, i_jr;
   logic       i_addiu, i_ori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
   logic       legal, ready, retire;
   logic       pc_we, ir_we, reg_we, dm_we, dm_re, illegal;
   logic [2:0] alu_dec, alu_ctr;
   logic [1:0] npc_sel;

   always_comb begin
      is_r    = (bus.op == 6'b000000);
      i_add   = is_r && (bus.funct == 6'b100000);
      i_sub   = is_r && (bus.funct == 6'b100010);
      i_and   = is_r && (bus.funct == 6'b100100);
      i_or    = is_r && (bus.funct == 6'b100101);
      i_slt   = is_r && (bus.funct == 6'b101010);
      i_jr    = is_r && (bus.funct == 6'b001000);
      i_addiu = (bus.op == 6'b001001);
      i_ori   = (bus.op == 6'b001101);
      i_lui   = (bus.op == 6'b001111);
      i_lw    = (bus.op == 6'b100011);
      i_sw    = (bus.op == 6'b101011);
      i_beq   = (bus.op == 6'b000100);
      i_bne   = (bus.op == 6'b000101);
      i_j     = (bus.op == 6'b000010);
      i_jal   = (bus.op == 6'b000011);
      legal   = i_add | i_sub | i_and | i_or | i_slt | i_jr | i_addiu | i_ori |
                i_lui | i_lw | i_sw | i_beq | i_bne | i_j | i_jal;

      if (i_add || i_addiu || i_lw || i_sw)       alu_dec = 3'b001;
      else if (i_sub || i_beq || i_bne)           alu_dec = 3'b010;
      else if (i_or || i_ori || i_lui)            alu_dec = 3'b011;
      else if (i_and)                             alu_dec = 3'b100;
      else if (i_slt)                             alu_dec = 3'b101;
      else                                        alu_dec = 3'b000;
   end

   assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

   // Static selects follow the IR in every state; the datapath only uses them when enabled.
   always_comb begin
      bus.ext_op         = i_ori ? 2'b00 : (i_lui ? 2'b01 : 2'b10);
      bus.alu_src_sel    = i_addiu | i_ori | i_lui | i_lw | i_sw;
      bus.reg_dst_sel    = is_r ? 2'b01 : (i_jal ? 2'b10 : 2'b00);
      bus.mem_to_reg_sel = i_lw ? 2'b01 : (i_jal ? 2'b10 : (i_lui ? 2'b11 : 2'b00));
   end

   always_comb begin
      state_nx = state;
      pc_we    = 1'b0;
      ir_we    = 1'b0;
      reg_we   = 1'b0;
      dm_we    = 1'b0;
      dm_re    = 1'b0;
      illegal  = 1'b0;
      alu_ctr  = 3'b000;
      npc_sel  = 2'b00;
      retire   = 1'b0;
      case (state)
         S_IF: begin
            ir_we = ready;
            pc_we = ready;
            if (ready) state_nx = S_ID;
         end
         S_ID: begin
            if (!legal) begin
               illegal  = 1'b1;
               state_nx = S_IF;
            end else if (i_j || i_jal || i_jr) begin
               // jal links here: regfile captures the old pc+4 on the same edge the PC jumps.
               pc_we    = 1'b1;
               npc_sel  = i_jr ? 2'b10 : 2'b01;
               reg_we   = i_jal;
               retire   = 1'b1;
               state_nx = S_IF;
            end else if (i_lw || i_sw) begin
               state_nx = S_EXE_MEM;
            end else if (i_beq || i_bne) begin
               state_nx = S_EXE_BR;
            end else begin
               state_nx = S_EXE_ALU;
            end
         end
         S_EXE_ALU: begin
            alu_ctr  = alu_dec;
            state_nx = S_WB_ALU;
         end
         S_EXE_BR: begin
            alu_ctr  = alu_dec;
            pc_we    = (i_beq & bus.zero) | (i_bne & ~bus.zero);
            npc_sel  = 2'b11;
            retire   = 1'b1;
            state_nx = S_IF;
         end
         S_EXE_MEM: begin
            alu_ctr  = alu_dec;
            state_nx = i_lw ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            dm_re = 1'b1;
            if (ready) state_nx = S_WB_LD;
         end
         S_MEM_WR: begin
            dm_we = 1'b1;
            if (ready) begin
               retire   = 1'b1;
               state_nx = S_IF;
            end
         end
         S_WB_ALU, S_WB_LD: begin
            reg_we   = 1'b1;
            retire   = 1'b1;
            state_nx = S_IF;
         end
         default: state_nx = S_IF;
      endcase
   end

   // Enables are gated by rst so nothing writes while reset is held, even in IF.
   always_comb begin
      bus.pc_we     = pc_we & rst;
      bus.ir_we     = ir_we & rst;
      bus.reg_we    = reg_we & rst;
      bus.dm_we     = dm_we & rst;
      bus.dm_re     = dm_re & rst;
      bus.illegal   = illegal & rst;
      bus.alu_ctr   = alu_ctr;
      bus.npc_sel   = npc_sel;
      bus.state_out = state;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IF;
         instret <= '0;
      end else begin
         state <= state_nx;
         if (retire) instret <= instret + CNT_ONE;
      end
   end

endmodule
